bench_run_ctrl: RTL

Synthesizable run-control stage that sits directly downstream of the bench clock generator and replaces the behavioural cycle counter and `$finish` watchdog of the VPI benchmark top. It counts clock edges against a programmable cycle limit and emits a one-cycle progress tick every `TICK_PERIOD` counts. It raises `done` when the limit is reached, so the enclosing bench (Verilog or C++ side through VPI) only has to watch `done` and `tick`.

---
 rtl/bench_pkg.sv | 14 +
 rtl/bench_run_ctrl_if.sv | 41 ++++
 rtl/tick_divider.sv | 36 +++
 rtl/bench_run_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/bench_pkg.sv
// Shared types and defaults for the bench run-control slice.
// State encoding plus the power-on cycle limit and tick period.
package bench_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned DEF_CYCLE       = 32'd4194304;
    localparam int          DEF_TICK_PERIOD = 1000000;

endpackage

// File: rtl/bench_run_ctrl_if.sv
// Config handshake, run control and status bundle of bench_run_ctrl.
// master drives config/start/abort; slave reports count and status.
interface bench_run_ctrl_if #(
    parameter int CNT_W = 32
) ();

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_cycle;
    logic             cfg_ready;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             running;
    logic             done;

    modport master (
        output cfg_valid,
        output cfg_cycle,
        output start,
        output abort,
        input  cfg_ready,
        input  count,
        input  tick,
        input  running,
        input  done
    );

    modport slave (
        input  cfg_valid,
        input  cfg_cycle,
        input  start,
        input  abort,
        output cfg_ready,
        output count,
        output tick,
        output running,
        output done
    );

endinterface

// File: rtl/tick_divider.sv
// Progress tick generator: one-cycle pulse every TICK_PERIOD enabled cycles.
// The pulse is registered so it lines up with the count it marks.
module tick_divider #(
    parameter int TICK_PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int SW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [SW-1:0] LAST = SW'(TICK_PERIOD - 1);

    logic [SW-1:0] sub_q;

    // Wrapping sub-counter in place of a modulo on the main count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sub_q <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (sub_q == LAST) begin
                sub_q <= '0;
                tick  <= 1'b1;
            end else begin
                sub_q <= sub_q + SW'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/bench_run_ctrl.sv
// Bench run control: counts cycles against a programmable limit,
// raises done at the limit and emits periodic progress ticks.
module bench_run_ctrl #(
    parameter int          CNT_W       = 32,
    parameter int          TICK_PERIOD = bench_pkg::DEF_TICK_PERIOD,
    parameter int unsigned DEF_CYCLE   = bench_pkg::DEF_CYCLE
) (
    input logic             clk,
    input logic             rst,
    bench_run_ctrl_if.slave bus
);

    import bench_pkg::*;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] limit_d;
    logic             running_q;
    logic             done_q;
    logic             tick_clr;
    logic             tick_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= CNT_W'(DEF_CYCLE);
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        tick_clr = 1'b0;
        tick_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    limit_d = bus.cfg_cycle;
                end
                if (bus.start) begin
                    count_d  = '0;
                    tick_clr = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Abort freezes count and skips the limit check.
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    tick_en = 1'b1;
                    if (count_d >= limit_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    count_d  = '0;
                    tick_clr = 1'b1;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    tick_divider #(
        .TICK_PERIOD(TICK_PERIOD)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .en  (tick_en),
        .tick(bus.tick)
    );

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.count     = count_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;

endmodule
